// File: rtl/hilo_mdu_ctrl.sv
// hilo_mdu_ctrl: sequencer for the iterative multiply/divide unit and the
// HI/LO register pair. MULT/MULTU run a shift-add multiply and DIV/DIVU run a
// restoring divide, one bit per cycle for DATA_W cycles. A final fix-up cycle
// applies the sign correction and writes HI/LO. MFHI/MFLO/MTHI/MTLO are served
// directly, and the pipeline is stalled while a result is still in flight.
module hilo_mdu_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              md_valid,
    input  logic [5:0]        funct,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    output logic              stall,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hilo_rdata,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t state;
    state_t state_nxt;

    // Shared 2*DATA_W-bit working register.
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits becoming quotient bits}.
    logic [2*DATA_W-1:0] acc;
    logic [DATA_W-1:0]   opb;
    logic [CNT_W-1:0]    cnt;
    logic                op_div;
    logic                neg_main;
    logic                neg_rem;
    logic                div_zero;

    logic                is_md;
    logic                is_hilo_op;
    logic                is_signed;
    logic                start;
    logic                rs_neg;
    logic                rt_neg;
    logic [DATA_W-1:0]   abs_rs;
    logic [DATA_W-1:0]   abs_rt;

    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] mul_next;
    logic [DATA_W:0]     div_trial;
    logic                div_ok;
    logic [2*DATA_W-1:0] div_next;

    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   quot_fix;
    logic [DATA_W-1:0]   rem_fix;

    // Decode of the instruction presented by the pipeline
    always_comb begin
        is_md      = (funct == F_MULT) || (funct == F_MULTU) ||
                     (funct == F_DIV)  || (funct == F_DIVU);
        is_hilo_op = is_md || (funct == F_MFHI) || (funct == F_MTHI) ||
                     (funct == F_MFLO) || (funct == F_MTLO);
        is_signed  = (funct == F_MULT) || (funct == F_DIV);
        start      = (state == S_IDLE) && md_valid && is_md;
        rs_neg     = is_signed && rs_data[DATA_W-1];
        rt_neg     = is_signed && rt_data[DATA_W-1];
        abs_rs     = rs_neg ? -rs_data : rs_data;
        abs_rt     = rt_neg ? -rt_data : rt_data;
    end

    // One iteration of shift-add multiply and of restoring divide
    always_comb begin
        mul_sum   = {1'b0, acc[2*DATA_W-1:DATA_W]} +
                    {1'b0, (acc[0] ? opb : {DATA_W{1'b0}})};
        mul_next  = {mul_sum, acc[DATA_W-1:1]};
        div_trial = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]} - {1'b0, opb};
        div_ok    = ~div_trial[DATA_W];
        div_next  = div_ok ? {div_trial[DATA_W-1:0], acc[DATA_W-2:0], 1'b1}
                           : {acc[2*DATA_W-2:0], 1'b0};
    end

    // Sign correction of the raw magnitudes, used in the fix-up cycle
    always_comb begin
        prod_fix = neg_main ? -acc : acc;
        quot_fix = div_zero ? {DATA_W{1'b1}}
                            : (neg_main ? -acc[DATA_W-1:0] : acc[DATA_W-1:0]);
        rem_fix  = neg_rem ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: IDLE -> RUN for DATA_W iterations -> FIX -> IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_RUN;
            S_RUN:  if (cnt == CNT_W'(DATA_W - 1)) state_nxt = S_FIX;
            S_FIX:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, HI/LO writes and the done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            opb      <= '0;
            cnt      <= '0;
            op_div   <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else begin
            done <= (state == S_FIX);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_div   <= funct[1];
                        neg_main <= rs_neg ^ rt_neg;
                        neg_rem  <= rs_neg;
                        div_zero <= funct[1] && (rt_data == '0);
                        cnt      <= '0;
                        if (funct[1]) begin
                            acc <= {{DATA_W{1'b0}}, abs_rs};
                            opb <= abs_rt;
                        end else begin
                            acc <= {{DATA_W{1'b0}}, abs_rt};
                            opb <= abs_rs;
                        end
                    end else if (md_valid && (funct == F_MTHI)) begin
                        hi <= rs_data;
                    end else if (md_valid && (funct == F_MTLO)) begin
                        lo <= rs_data;
                    end
                end
                S_RUN: begin
                    acc <= op_div ? div_next : mul_next;
                    cnt <= cnt + 1'b1;
                end
                S_FIX: begin
                    if (op_div) begin
                        hi <= rem_fix;
                        lo <= quot_fix;
                    end else begin
                        hi <= prod_fix[2*DATA_W-1:DATA_W];
                        lo <= prod_fix[DATA_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    // Status outputs and the MFHI/MFLO read port
    always_comb begin
        busy  = (state != S_IDLE);
        stall = busy && md_valid && is_hilo_op;
        hilo_rdata = '0;
        if (funct == F_MFHI) hilo_rdata = hi;
        else if (funct == F_MFLO) hilo_rdata = lo;
    end

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// tb_hilo_mdu_ctrl: randomized and directed bench for hilo_mdu_ctrl. Expected
// HI/LO values come from plain 64-bit arithmetic; expected timing comes from
// the fixed DATA_W+1 cycle latency of every multiply/divide.
module tb_hilo_mdu_ctrl;

    localparam int DATA_W = 32;
    localparam int LAT    = DATA_W + 1;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;

    logic              clk;
    logic              rst;
    logic              md_valid;
    logic [5:0]        funct;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              stall;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] hilo_rdata;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    int checks;
    int failures;

    logic [DATA_W-1:0] m_hi;
    logic [DATA_W-1:0] m_lo;

    hilo_mdu_ctrl #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .md_valid  (md_valid),
        .funct     (funct),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .stall     (stall),
        .busy      (busy),
        .done      (done),
        .hilo_rdata(hilo_rdata),
        .hi        (hi),
        .lo        (lo)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point for the whole bench
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Architectural result of a multiply/divide, returned as {hi, lo}
    function automatic logic [63:0] refResult(input logic [5:0] f,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint          q;
        longint          r;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     res;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'h0, a};
        ub = {32'h0, b};
        res = '0;
        case (f)
            F_MULT:  res = sa * sb;
            F_MULTU: res = ua * ub;
            F_DIV: begin
                if (b == 32'h0) begin
                    res = {a, 32'hFFFF_FFFF};
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            F_DIVU: begin
                if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
                else res = {a % b, a / b};
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    function automatic bit isHiloClass(input logic [5:0] f);
        return (f >= 6'h10 && f <= 6'h13) || (f >= 6'h18 && f <= 6'h1B);
    endfunction

    // Issue one multiply/divide, present a second instruction while it runs,
    // and check latency, busy/stall windows, the done pulse and HI/LO.
    task automatic applyStimulus(input logic [5:0] f, input logic [31:0] a,
                                 input logic [31:0] b, input logic hold_valid,
                                 input logic [5:0] hold_f, input logic [31:0] hold_rs);
        logic [63:0] exp;
        int busy_cycles;
        int stall_cycles;
        int early_done;
        int rdata_bad;
        int exp_stall;
        exp = refResult(f, a, b);
        md_valid = 1'b1;
        funct    = f;
        rs_data  = a;
        rt_data  = b;
        #1;
        checkOutput("issue_stall", {63'h0, stall}, 64'h0);
        tick();
        md_valid = hold_valid;
        funct    = hold_f;
        rs_data  = hold_rs;
        rt_data  = $urandom;
        busy_cycles  = 0;
        stall_cycles = 0;
        early_done   = 0;
        rdata_bad    = 0;
        for (int n = 0; n < LAT; n++) begin
            #1;
            if (busy) busy_cycles++;
            if (stall) stall_cycles++;
            if (done) early_done++;
            if (hold_f == F_MFHI && hilo_rdata !== m_hi) rdata_bad++;
            if (hold_f == F_MFLO && hilo_rdata !== m_lo) rdata_bad++;
            tick();
        end
        exp_stall = (hold_valid && isHiloClass(hold_f)) ? LAT : 0;
        #1;
        checkOutput("busy_cycles", 64'(busy_cycles), 64'(LAT));
        checkOutput("stall_cycles", 64'(stall_cycles), 64'(exp_stall));
        checkOutput("early_done", 64'(early_done), 64'h0);
        checkOutput("held_rdata", 64'(rdata_bad), 64'h0);
        checkOutput("done_pulse", {63'h0, done}, 64'h1);
        checkOutput("done_busy", {63'h0, busy}, 64'h0);
        checkOutput("done_stall", {63'h0, stall}, 64'h0);
        checkOutput("result_hi", {32'h0, hi}, {32'h0, exp[63:32]});
        checkOutput("result_lo", {32'h0, lo}, {32'h0, exp[31:0]});
        m_hi = exp[63:32];
        m_lo = exp[31:0];
        if (hold_f == F_MFHI) checkOutput("done_rdata_hi", {32'h0, hilo_rdata}, {32'h0, m_hi});
        if (hold_f == F_MFLO) checkOutput("done_rdata_lo", {32'h0, hilo_rdata}, {32'h0, m_lo});
        if (hold_valid && hold_f == F_MTHI) m_hi = hold_rs;
        if (hold_valid && hold_f == F_MTLO) m_lo = hold_rs;
        tick();
        md_valid = 1'b0;
        funct    = F_ADD;
        #1;
        checkOutput("done_single", {63'h0, done}, 64'h0);
        checkOutput("after_hi", {32'h0, hi}, {32'h0, m_hi});
        checkOutput("after_lo", {32'h0, lo}, {32'h0, m_lo});
    endtask

    // Main sequence: reset, directed cases, randomized cases, reset abort
    initial begin
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  hf;
        logic        hv;
        int          done_seen;
        int          kind;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        md_valid = 1'b0;
        funct    = F_ADD;
        rs_data  = '0;
        rt_data  = '0;
        m_hi     = '0;
        m_lo     = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checkOutput("reset_busy", {63'h0, busy}, 64'h0);
        checkOutput("reset_done", {63'h0, done}, 64'h0);
        checkOutput("reset_hi", {32'h0, hi}, 64'h0);
        checkOutput("reset_lo", {32'h0, lo}, 64'h0);

        applyStimulus(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, F_ADD, 32'h0);
        applyStimulus(F_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 1'b1, F_MFHI, 32'h0);
        applyStimulus(F_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 1'b1, F_ADD, 32'h0);
        applyStimulus(F_DIVU,  32'h0000_0007, 32'h0000_0000, 1'b0, F_ADD, 32'h0);
        applyStimulus(F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b1, F_MFLO, 32'h0);
        applyStimulus(F_DIV,   32'hFFFF_FFF0, 32'h0000_0000, 1'b1, F_MTLO, 32'hCAFE_0001);

        // MTHI in IDLE followed by MFHI
        md_valid = 1'b1;
        funct    = F_MTHI;
        rs_data  = 32'h1234_5678;
        #1;
        checkOutput("mthi_stall", {63'h0, stall}, 64'h0);
        tick();
        m_hi  = 32'h1234_5678;
        funct = F_MFHI;
        #1;
        checkOutput("mfhi_rdata", {32'h0, hilo_rdata}, 64'h1234_5678);
        checkOutput("mfhi_stall", {63'h0, stall}, 64'h0);
        checkOutput("mthi_lo_kept", {32'h0, lo}, {32'h0, m_lo});
        funct = F_MFLO;
        #1;
        checkOutput("mflo_rdata", {32'h0, hilo_rdata}, {32'h0, m_lo});
        md_valid = 1'b0;
        funct    = F_ADD;
        tick();

        // Randomized operations, operand corners and instructions held while busy
        for (int i = 0; i < 24; i++) begin
            f = 6'h18 + 6'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 9));
                3: a = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
                default: ;
            endcase
            kind = $urandom_range(0, 5);
            hv = (kind != 0);
            case (kind)
                1: hf = F_MFHI;
                2: hf = F_MFLO;
                3: hf = F_MTHI;
                4: hf = F_MTLO;
                default: hf = F_ADD;
            endcase
            applyStimulus(f, a, b, hv, hf, $urandom);
        end

        // Reset in the middle of a divide discards it
        md_valid = 1'b1;
        funct    = F_DIVU;
        rs_data  = 32'd100;
        rt_data  = 32'd3;
        tick();
        md_valid = 1'b0;
        funct    = F_ADD;
        for (int n = 0; n < 9; n++) tick();
        rst = 1'b1;
        tick();
        rst  = 1'b0;
        m_hi = '0;
        m_lo = '0;
        checkOutput("abort_busy", {63'h0, busy}, 64'h0);
        checkOutput("abort_hi", {32'h0, hi}, 64'h0);
        checkOutput("abort_lo", {32'h0, lo}, 64'h0);
        done_seen = 0;
        for (int n = 0; n < LAT + 4; n++) begin
            if (done || busy) done_seen++;
            tick();
        end
        checkOutput("abort_no_done", 64'(done_seen), 64'h0);
        applyStimulus(F_DIVU, 32'd100, 32'd3, 1'b0, F_ADD, 32'h0);
        checkOutput("fresh_divu_lo", {32'h0, lo}, 64'd33);
        checkOutput("fresh_divu_hi", {32'h0, hi}, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
